// File: rtl/draw_sequencer_if.sv
// Bus and pipeline-stage signal bundle for draw_sequencer.
// The slave modport is the sequencer's view; master is the CPU/stage side.
interface draw_sequencer_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   i_bus_we;
    logic [ADDR_WIDTH-1:0]  i_bus_addr;
    logic [DATA_WIDTH-1:0]  i_bus_wdata;
    logic [DATA_WIDTH-1:0]  o_bus_rdata;
    logic                   o_fetch_start;
    logic [ADDR_WIDTH-1:0]  o_fetch_base;
    logic [COUNT_WIDTH-1:0] o_fetch_index;
    logic [1:0]             o_fetch_nverts;
    logic                   i_fetch_done;
    logic                   o_shader_en;
    logic [DATA_WIDTH-1:0]  o_shader_pc;
    logic                   o_rast_start;
    logic [1:0]             o_rast_mode;
    logic                   o_rast_flip;
    logic                   i_rast_done;
    logic                   i_frag_idle;
    logic                   o_busy;
    logic                   o_irq;

    modport slave (
        input  i_bus_we, i_bus_addr, i_bus_wdata, i_fetch_done, i_rast_done, i_frag_idle,
        output o_bus_rdata, o_fetch_start, o_fetch_base, o_fetch_index, o_fetch_nverts,
               o_shader_en, o_shader_pc, o_rast_start, o_rast_mode, o_rast_flip, o_busy, o_irq
    );

    modport master (
        output i_bus_we, i_bus_addr, i_bus_wdata, i_fetch_done, i_rast_done, i_frag_idle,
        input  o_bus_rdata, o_fetch_start, o_fetch_base, o_fetch_index, o_fetch_nverts,
               o_shader_en, o_shader_pc, o_rast_start, o_rast_mode, o_rast_flip, o_busy, o_irq
    );
endinterface

// File: rtl/draw_sequencer.sv
// Draw-call sequencer: CPU register block plus the fetch/shade/rasterize/drain loop
// with selectable primitive modes, per-stage watchdog, abort and sticky irq/err.
module draw_sequencer #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    draw_sequencer_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] AddrControl  = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] AddrStatus   = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] AddrBase     = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] AddrCount    = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] AddrPc       = ADDR_WIDTH'('h10);
    localparam logic [ADDR_WIDTH-1:0] AddrMode     = ADDR_WIDTH'('h14);
    localparam logic [ADDR_WIDTH-1:0] AddrPrimDone = ADDR_WIDTH'('h18);
    localparam logic [ADDR_WIDTH-1:0] AddrTimeout  = ADDR_WIDTH'('h1C);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShade,
        StRast,
        StDrain,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]    vertex_base_q;
    logic [COUNT_WIDTH-1:0]   vertex_count_q;
    logic [DATA_WIDTH-1:0]    pc_q;
    logic [1:0]               mode_q;
    logic [COUNT_WIDTH-1:0]   prim_done_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic [TIMEOUT_WIDTH-1:0] wd_q;
    logic                     err_q;
    logic                     irq_q;
    logic [COUNT_WIDTH:0]     idx_q;
    logic [COUNT_WIDTH-1:0]   fetch_index_q;
    logic [1:0]               fetch_nverts_q;
    logic                     fetch_start_q;
    logic                     shader_en_q;
    logic                     rast_start_q;

    logic                  busy;
    logic                  ctrl_wr;
    logic                  start_req;
    logic                  abort_req;
    logic                  irq_clr;
    logic                  cfg_wr;
    logic [1:0]            nverts;
    logic [1:0]            stride;
    logic                  first_fits;
    logic                  next_fits;
    logic                  counting;
    logic                  wd_expire;
    logic                  draw_start;
    logic                  fetch_ack;
    logic                  prim_inc;
    logic                  set_irq;
    logic                  set_err;
    logic [DATA_WIDTH-1:0] rdata;

    assign busy      = (state_q != StIdle);
    assign ctrl_wr   = bus.i_bus_we && (bus.i_bus_addr == AddrControl);
    assign start_req = ctrl_wr && bus.i_bus_wdata[0];
    assign abort_req = ctrl_wr && bus.i_bus_wdata[1];
    assign irq_clr   = ctrl_wr && bus.i_bus_wdata[2];
    // Config is frozen for the whole draw.
    assign cfg_wr    = bus.i_bus_we && !busy;

    always_comb begin
        nverts = 2'd1;
        stride = 2'd1;
        unique case (mode_q)
            2'd0: begin nverts = 2'd1; stride = 2'd1; end
            2'd1: begin nverts = 2'd2; stride = 2'd2; end
            2'd2: begin nverts = 2'd3; stride = 2'd3; end
            2'd3: begin nverts = 2'd3; stride = 2'd1; end
        endcase
    end

    // One extra bit on the index so index + V never wraps.
    assign first_fits = (COUNT_WIDTH'(nverts) <= vertex_count_q);
    assign next_fits  = ((idx_q + (COUNT_WIDTH+1)'(nverts)) <= {1'b0, vertex_count_q});

    assign counting  = (state_q == StFetch) || (state_q == StRast) || (state_q == StDrain);
    assign wd_expire = (timeout_q != '0) && ((wd_q + TIMEOUT_WIDTH'(1)) == timeout_q);

    always_comb begin
        state_d    = state_q;
        draw_start = 1'b0;
        fetch_ack  = 1'b0;
        prim_inc   = 1'b0;
        set_irq    = 1'b0;
        set_err    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    draw_start = 1'b1;
                    state_d    = first_fits ? StFetch : StDone;
                end
            end
            StFetch: begin
                if (bus.i_fetch_done) begin
                    fetch_ack = 1'b1;
                    state_d   = StShade;
                end else if (wd_expire) begin
                    set_err = 1'b1;
                    state_d = StIdle;
                end
            end
            StShade: state_d = StRast;
            StRast: begin
                if (bus.i_rast_done) begin
                    prim_inc = 1'b1;
                    state_d  = next_fits ? StFetch : StDrain;
                end else if (wd_expire) begin
                    set_err = 1'b1;
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (bus.i_frag_idle) begin
                    state_d = StDone;
                end else if (wd_expire) begin
                    set_err = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: begin
                set_irq = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides every other event in the cycle.
        if (abort_req && busy) begin
            state_d   = StIdle;
            fetch_ack = 1'b0;
            prim_inc  = 1'b0;
            set_irq   = 1'b0;
            set_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            fetch_start_q  <= 1'b0;
            shader_en_q    <= 1'b0;
            rast_start_q   <= 1'b0;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            fetch_start_q  <= (state_d == StFetch) && (state_q != StFetch);
            shader_en_q    <= (state_d == StShade) && (state_q != StShade);
            rast_start_q   <= (state_d == StRast) && (state_q != StRast);
            if ((state_d != state_q) || !counting) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + TIMEOUT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q          <= '0;
            fetch_index_q  <= '0;
            fetch_nverts_q <= '0;
            prim_done_q    <= '0;
            err_q          <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            if (draw_start) begin
                idx_q <= '0;
            end else if (fetch_ack) begin
                idx_q <= idx_q + (COUNT_WIDTH+1)'(stride);
            end
            if ((state_d == StFetch) && (state_q != StFetch)) begin
                fetch_index_q  <= draw_start ? '0 : idx_q[COUNT_WIDTH-1:0];
                fetch_nverts_q <= nverts;
            end
            if (draw_start) begin
                prim_done_q <= '0;
            end else if (prim_inc) begin
                prim_done_q <= prim_done_q + COUNT_WIDTH'(1);
            end
            if (draw_start) begin
                err_q <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
            // A set in the same cycle as a clear wins.
            if (set_irq || set_err) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vertex_base_q  <= '0;
            vertex_count_q <= '0;
            pc_q           <= '0;
            mode_q         <= '0;
            timeout_q      <= '0;
        end else if (cfg_wr) begin
            case (bus.i_bus_addr)
                AddrBase:    vertex_base_q  <= ADDR_WIDTH'(bus.i_bus_wdata);
                AddrCount:   vertex_count_q <= bus.i_bus_wdata[COUNT_WIDTH-1:0];
                AddrPc:      pc_q           <= bus.i_bus_wdata;
                AddrMode:    mode_q         <= bus.i_bus_wdata[1:0];
                AddrTimeout: timeout_q      <= bus.i_bus_wdata[TIMEOUT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.i_bus_addr)
            AddrStatus:   rdata = DATA_WIDTH'({err_q, irq_q, busy});
            AddrBase:     rdata = DATA_WIDTH'(vertex_base_q);
            AddrCount:    rdata = DATA_WIDTH'(vertex_count_q);
            AddrPc:       rdata = pc_q;
            AddrMode:     rdata = DATA_WIDTH'(mode_q);
            AddrPrimDone: rdata = DATA_WIDTH'(prim_done_q);
            AddrTimeout:  rdata = DATA_WIDTH'(timeout_q);
            default:      rdata = '0;
        endcase
    end

    assign bus.o_bus_rdata    = rdata;
    assign bus.o_fetch_start  = fetch_start_q;
    assign bus.o_fetch_base   = vertex_base_q;
    assign bus.o_fetch_index  = fetch_index_q;
    assign bus.o_fetch_nverts = fetch_nverts_q;
    assign bus.o_shader_en    = shader_en_q;
    assign bus.o_shader_pc    = pc_q;
    assign bus.o_rast_start   = rast_start_q;
    // Strips rasterize as triangles; odd strip primitives swap winding.
    assign bus.o_rast_mode    = (mode_q == 2'd3) ? 2'd2 : mode_q;
    assign bus.o_rast_flip    = (mode_q == 2'd3) && fetch_index_q[0];
    assign bus.o_busy         = busy;
    assign bus.o_irq          = irq_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard bench for draw_sequencer: expected stage pulses are queued when a draw
// is launched and popped as the sequencer issues them.
module tb_draw_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 16;

    localparam logic [AW-1:0] ACtrl   = 32'h00;
    localparam logic [AW-1:0] AStatus = 32'h04;
    localparam logic [AW-1:0] ABase   = 32'h08;
    localparam logic [AW-1:0] ACount  = 32'h0C;
    localparam logic [AW-1:0] APc     = 32'h10;
    localparam logic [AW-1:0] AMode   = 32'h14;
    localparam logic [AW-1:0] APrim   = 32'h18;
    localparam logic [AW-1:0] ATmo    = 32'h1C;

    typedef struct packed {
        logic [CW-1:0] idx;
        logic [1:0]    nv;
    } fetch_exp_t;

    typedef struct packed {
        logic [1:0] mode;
        logic       flip;
    } rast_exp_t;

    logic clk;
    logic rst;

    draw_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    draw_sequencer #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .COUNT_WIDTH  (CW),
        .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    fetch_exp_t    exp_fetch_q[$];
    rast_exp_t     exp_rast_q[$];
    logic [DW-1:0] exp_pc_q[$];
    logic [AW-1:0] exp_base;
    logic [DW-1:0] exp_pc;
    fetch_exp_t    mon_fe;
    rast_exp_t     mon_re;
    logic [DW-1:0] mon_pc;
    int            n_checks = 0;
    int            n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end of test, expected $finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        bus.i_bus_we    = 1'b1;
        bus.i_bus_addr  = addr;
        bus.i_bus_wdata = data;
        @(negedge clk);
        bus.i_bus_we    = 1'b0;
    endtask

    task automatic expect_read(input string tag, input logic [AW-1:0] addr,
                               input logic [DW-1:0] exp);
        bus.i_bus_addr = addr;
        #1;
        check(tag, 64'(bus.o_bus_rdata), 64'(exp));
    endtask

    task automatic push_fetch(input int idx, input int nv);
        fetch_exp_t fe;
        fe.idx = CW'(idx);
        fe.nv  = 2'(nv);
        exp_fetch_q.push_back(fe);
    endtask

    task automatic push_shade_rast(input int mode, input int flip);
        rast_exp_t re;
        re.mode = 2'(mode);
        re.flip = 1'(flip);
        exp_rast_q.push_back(re);
        exp_pc_q.push_back(exp_pc);
    endtask

    // Answers every stage pulse in its own cycle; holds i_frag_idle low for drain_wait
    // drain cycles.
    task automatic serve(input int n_prims, input int drain_wait, input int bound);
        int  rast_seen = 0;
        int  drain_cnt = 0;
        bit  ended     = 1'b0;
        bus.i_frag_idle = 1'b0;
        for (int c = 0; c < bound && !ended; c++) begin
            if (!bus.o_busy) begin
                ended = 1'b1;
            end else begin
                bus.i_fetch_done = bus.o_fetch_start;
                bus.i_rast_done  = bus.o_rast_start;
                if (bus.o_rast_start) begin
                    rast_seen++;
                end else if (rast_seen == n_prims) begin
                    drain_cnt++;
                end
                bus.i_frag_idle = (drain_cnt > drain_wait);
                @(negedge clk);
            end
        end
        bus.i_fetch_done = 1'b0;
        bus.i_rast_done  = 1'b0;
        bus.i_frag_idle  = 1'b1;
        check("draw_end_busy", 64'(bus.o_busy), 64'd0);
        check("drain_cycles", 64'(drain_cnt), 64'(drain_wait + 2));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_fetch_start) begin
                if (exp_fetch_q.size() == 0) begin
                    check("fetch_extra", 64'(bus.o_fetch_start), 64'd0);
                end else begin
                    mon_fe = exp_fetch_q.pop_front();
                    check("fetch_index", 64'(bus.o_fetch_index), 64'(mon_fe.idx));
                    check("fetch_nverts", 64'(bus.o_fetch_nverts), 64'(mon_fe.nv));
                    check("fetch_base", 64'(bus.o_fetch_base), 64'(exp_base));
                end
            end
            if (bus.o_shader_en) begin
                if (exp_pc_q.size() == 0) begin
                    check("shader_extra", 64'(bus.o_shader_en), 64'd0);
                end else begin
                    mon_pc = exp_pc_q.pop_front();
                    check("shader_pc", 64'(bus.o_shader_pc), 64'(mon_pc));
                end
            end
            if (bus.o_rast_start) begin
                if (exp_rast_q.size() == 0) begin
                    check("rast_extra", 64'(bus.o_rast_start), 64'd0);
                end else begin
                    mon_re = exp_rast_q.pop_front();
                    check("rast_mode", 64'(bus.o_rast_mode), 64'(mon_re.mode));
                    check("rast_flip", 64'(bus.o_rast_flip), 64'(mon_re.flip));
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.i_bus_we     = 1'b0;
        bus.i_bus_addr   = '0;
        bus.i_bus_wdata  = '0;
        bus.i_fetch_done = 1'b0;
        bus.i_rast_done  = 1'b0;
        bus.i_frag_idle  = 1'b1;
        exp_base         = '0;
        exp_pc           = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_irq", 64'(bus.o_irq), 64'd0);
        check("rst_fetch_start", 64'(bus.o_fetch_start), 64'd0);
        check("rst_nverts", 64'(bus.o_fetch_nverts), 64'd0);
        check("rst_rast_mode", 64'(bus.o_rast_mode), 64'd0);
        expect_read("rst_status", AStatus, 32'd0);
        expect_read("rst_count", ACount, 32'd0);
        rst = 1'b0;

        // Register access
        exp_base = 32'h0000_1000;
        exp_pc   = 32'h0000_0080;
        bus_write(ABase, exp_base);
        bus_write(APc, exp_pc);
        bus_write(32'h20, 32'hDEAD_BEEF);
        bus_write(APrim, 32'd5);
        expect_read("rd_base", ABase, exp_base);
        expect_read("rd_pc", APc, exp_pc);
        expect_read("rd_unmapped", 32'h20, 32'd0);
        expect_read("rd_prim_ro", APrim, 32'd0);

        // Triangle list: two primitives, drain held for 3 cycles
        bus_write(ACount, 32'd6);
        bus_write(AMode, 32'd2);
        expect_read("rd_mode", AMode, 32'd2);
        push_fetch(0, 3); push_shade_rast(2, 0);
        push_fetch(3, 3); push_shade_rast(2, 0);
        bus_write(ACtrl, 32'd1);
        check("tri_start_pulse", 64'(bus.o_fetch_start), 64'd1);
        serve(2, 3, 200);
        expect_read("tri_prim_done", APrim, 32'd2);
        expect_read("tri_status", AStatus, 32'd2);

        // Triangle strip: alternating winding
        bus_write(ACtrl, 32'd4);
        bus_write(ACount, 32'd5);
        bus_write(AMode, 32'd3);
        push_fetch(0, 3); push_shade_rast(2, 0);
        push_fetch(1, 3); push_shade_rast(2, 1);
        push_fetch(2, 3); push_shade_rast(2, 0);
        bus_write(ACtrl, 32'd1);
        serve(3, 1, 200);
        expect_read("strip_prim_done", APrim, 32'd3);

        // Empty draw: nothing fits, straight to DONE
        bus_write(ACtrl, 32'd4);
        bus_write(ACount, 32'd2);
        bus_write(AMode, 32'd2);
        bus_write(ACtrl, 32'd1);
        expect_read("empty_status_busy", AStatus, 32'd1);
        @(negedge clk);
        expect_read("empty_status_irq", AStatus, 32'd2);
        expect_read("empty_prim_done", APrim, 32'd0);

        // Watchdog fires 8 cycles after FETCH entry
        bus_write(ACtrl, 32'd4);
        bus_write(ACount, 32'd3);
        bus_write(AMode, 32'd0);
        bus_write(ATmo, 32'd8);
        push_fetch(0, 1);
        bus_write(ACtrl, 32'd1);
        repeat (7) @(negedge clk);
        check("wd_before_expiry", 64'(bus.o_busy), 64'd1);
        @(negedge clk);
        expect_read("wd_status", AStatus, 32'd6);
        check("wd_irq", 64'(bus.o_irq), 64'd1);

        // Watchdog disabled: waits indefinitely, then abort
        bus_write(ACtrl, 32'd4);
        bus_write(ATmo, 32'd0);
        push_fetch(0, 1);
        bus_write(ACtrl, 32'd1);
        expect_read("wd_off_err_cleared", AStatus, 32'd1);
        repeat (100) @(negedge clk);
        check("wd_off_busy", 64'(bus.o_busy), 64'd1);
        bus_write(ACtrl, 32'd2);
        expect_read("wd_off_abort_status", AStatus, 32'd0);

        // Abort together with i_rast_done
        bus_write(ACount, 32'd6);
        bus_write(AMode, 32'd1);
        push_fetch(0, 2); push_shade_rast(1, 0);
        bus_write(ACtrl, 32'd1);
        bus.i_fetch_done = 1'b1;
        @(negedge clk);
        bus.i_fetch_done = 1'b0;
        @(negedge clk);
        check("abort_in_rast", 64'(bus.o_rast_start), 64'd1);
        bus.i_rast_done = 1'b1;
        bus.i_bus_we    = 1'b1;
        bus.i_bus_addr  = ACtrl;
        bus.i_bus_wdata = 32'd2;
        @(negedge clk);
        bus.i_rast_done = 1'b0;
        bus.i_bus_we    = 1'b0;
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        expect_read("abort_prim_done", APrim, 32'd0);
        expect_read("abort_status", AStatus, 32'd0);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 64'(bus.o_busy), 64'd0);

        // Busy protection
        bus_write(ACount, 32'd3);
        bus_write(AMode, 32'd2);
        push_fetch(0, 3); push_shade_rast(2, 0);
        bus_write(ACtrl, 32'd1);
        bus.i_fetch_done = 1'b1;
        bus.i_bus_we     = 1'b1;
        bus.i_bus_addr   = ACount;
        bus.i_bus_wdata  = 32'd99;
        @(negedge clk);
        bus.i_fetch_done = 1'b0;
        bus.i_bus_addr   = ACtrl;
        bus.i_bus_wdata  = 32'd1;
        @(negedge clk);
        bus.i_bus_we    = 1'b0;
        bus.i_rast_done = 1'b1;
        @(negedge clk);
        bus.i_rast_done = 1'b0;
        @(negedge clk);
        check("prot_done_busy", 64'(bus.o_busy), 64'd1);
        bus.i_bus_we    = 1'b1;
        bus.i_bus_addr  = ACtrl;
        bus.i_bus_wdata = 32'd4;
        @(negedge clk);
        bus.i_bus_we = 1'b0;
        check("prot_idle", 64'(bus.o_busy), 64'd0);
        check("prot_irq_set_wins", 64'(bus.o_irq), 64'd1);
        expect_read("prot_count", ACount, 32'd3);
        expect_read("prot_prim_done", APrim, 32'd1);
        repeat (5) @(negedge clk);
        check("prot_no_restart", 64'(bus.o_busy), 64'd0);

        check("fetch_q_left", 64'(exp_fetch_q.size()), 64'd0);
        check("rast_q_left", 64'(exp_rast_q.size()), 64'd0);
        check("pc_q_left", 64'(exp_pc_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
